// File: rtl/button_conditioner.sv
// Synchronises, debounces and auto-repeats two active-low push-buttons. Each step event is
// presented as an active-low button pulse and a one-cycle strobe.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter bit REPEAT_EN           = 1'b1,
    parameter int REPEAT_DELAY_CYCLES = 25000000,
    parameter int REPEAT_RATE_CYCLES  = 5000000,
    parameter int PULSE_CYCLES        = 4,
    parameter int CNT_BIT             = 26
) (
    input  logic i_CLK,
    input  logic i_RST,
    input  logic i_btn_inc_n,
    input  logic i_btn_dec_n,
    output logic o_inc_btn,
    output logic o_dec_btn,
    output logic o_inc_pulse,
    output logic o_dec_pulse,
    output logic o_held,
    output logic o_conflict
);

    localparam logic [CNT_BIT-1:0] DEB_LAST   = CNT_BIT'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_BIT-1:0] DELAY_LOAD = CNT_BIT'(REPEAT_DELAY_CYCLES);
    localparam logic [CNT_BIT-1:0] RATE_LOAD  = CNT_BIT'(REPEAT_RATE_CYCLES);
    localparam logic [CNT_BIT-1:0] PULSE_LAST = CNT_BIT'(PULSE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FIRST, HOLD, REPEAT, LOCK} state_t;

    // Channel index 0 is increase, 1 is decrease; all levels here are active-low.
    logic [1:0]              sync_meta;
    logic [1:0]              sync_n;
    logic [1:0]              deb_n;
    logic [1:0][CNT_BIT-1:0] deb_cnt;

    state_t             state, state_next;
    logic               chan_dec, chan_dec_next;
    logic [CNT_BIT-1:0] rpt_cnt, rpt_cnt_next;
    logic               ev_inc, ev_dec;
    logic               inc_p, dec_p, own_p, other_p;
    logic [CNT_BIT-1:0] inc_pw, dec_pw;

    assign inc_p   = ~deb_n[0];
    assign dec_p   = ~deb_n[1];
    assign own_p   = chan_dec ? dec_p : inc_p;
    assign other_p = chan_dec ? inc_p : dec_p;

    // The >= compare keeps the debounce counter from ever wrapping.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            sync_meta <= 2'b11;
            sync_n    <= 2'b11;
            deb_n     <= 2'b11;
            deb_cnt   <= '0;
        end else begin
            sync_meta <= {i_btn_dec_n, i_btn_inc_n};
            sync_n    <= sync_meta;
            for (int ch = 0; ch < 2; ch++) begin
                if (sync_n[ch] == deb_n[ch]) begin
                    deb_cnt[ch] <= '0;
                end else if (deb_cnt[ch] >= DEB_LAST) begin
                    deb_n[ch]   <= ~deb_n[ch];
                    deb_cnt[ch] <= '0;
                end else begin
                    deb_cnt[ch] <= deb_cnt[ch] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state    <= IDLE;
            chan_dec <= 1'b0;
            rpt_cnt  <= '0;
        end else begin
            state    <= state_next;
            chan_dec <= chan_dec_next;
            rpt_cnt  <= rpt_cnt_next;
        end
    end

    // Release of the owning button wins over conflict, which wins over a repeat expiry.
    always_comb begin
        state_next    = state;
        chan_dec_next = chan_dec;
        rpt_cnt_next  = rpt_cnt;
        ev_inc        = 1'b0;
        ev_dec        = 1'b0;
        unique case (state)
            IDLE: begin
                if (inc_p && dec_p) begin
                    state_next = LOCK;
                end else if (inc_p || dec_p) begin
                    state_next    = FIRST;
                    chan_dec_next = dec_p;
                end
            end
            FIRST: begin
                ev_inc       = !chan_dec;
                ev_dec       = chan_dec;
                rpt_cnt_next = DELAY_LOAD;
                state_next   = HOLD;
            end
            HOLD, REPEAT: begin
                if (!own_p) begin
                    state_next = IDLE;
                end else if (other_p) begin
                    state_next = LOCK;
                end else if (rpt_cnt == '0) begin
                    if (REPEAT_EN) begin
                        ev_inc       = !chan_dec;
                        ev_dec       = chan_dec;
                        rpt_cnt_next = RATE_LOAD;
                        state_next   = REPEAT;
                    end
                end else begin
                    rpt_cnt_next = rpt_cnt - 1'b1;
                end
            end
            LOCK: begin
                if (!inc_p && !dec_p) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pulse timers run independently of the FSM so a started pulse always completes.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            o_inc_btn   <= 1'b1;
            o_dec_btn   <= 1'b1;
            o_inc_pulse <= 1'b0;
            o_dec_pulse <= 1'b0;
            o_held      <= 1'b0;
            o_conflict  <= 1'b0;
            inc_pw      <= '0;
            dec_pw      <= '0;
        end else begin
            o_inc_pulse <= ev_inc;
            o_dec_pulse <= ev_dec;
            o_held      <= inc_p | dec_p;
            o_conflict  <= (state_next == LOCK);
            if (ev_inc) begin
                o_inc_btn <= 1'b0;
                inc_pw    <= PULSE_LAST;
            end else if (!o_inc_btn) begin
                if (inc_pw == '0) o_inc_btn <= 1'b1;
                else              inc_pw    <= inc_pw - 1'b1;
            end
            if (ev_dec) begin
                o_dec_btn <= 1'b0;
                dec_pw    <= PULSE_LAST;
            end else if (!o_dec_btn) begin
                if (dec_pw == '0) o_dec_btn <= 1'b1;
                else              dec_pw    <= dec_pw - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected event cycles are queued when buttons are
// driven and matched against strobes; a second instance runs with auto-repeat disabled.
module tb_button_conditioner;

    localparam int DEB   = 4;
    localparam int RDLY  = 20;
    localparam int RRATE = 8;
    localparam int PW    = 2;
    localparam int STEP  = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic inc_n = 1'b1, dec_n = 1'b1, dec2_n = 1'b1;
    logic inc_btn, dec_btn, inc_pulse, dec_pulse, held, conflict;
    logic inc2_btn, dec2_btn, inc2_pulse, dec2_pulse, held2, conflict2;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int inc_q[$], dec_q[$], dec2_q[$];
    int inc_run = 0, dec_run = 0, dec2_run = 0;
    int value_model = 100;
    logic dec2_prev = 1'b1;

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b1), .REPEAT_DELAY_CYCLES(RDLY),
        .REPEAT_RATE_CYCLES(RRATE), .PULSE_CYCLES(PW), .CNT_BIT(8)
    ) dut (
        .i_CLK(clk), .i_RST(rst_n), .i_btn_inc_n(inc_n), .i_btn_dec_n(dec_n),
        .o_inc_btn(inc_btn), .o_dec_btn(dec_btn), .o_inc_pulse(inc_pulse),
        .o_dec_pulse(dec_pulse), .o_held(held), .o_conflict(conflict)
    );

    button_conditioner #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1'b0), .REPEAT_DELAY_CYCLES(RDLY),
        .REPEAT_RATE_CYCLES(RRATE), .PULSE_CYCLES(PW), .CNT_BIT(8)
    ) dut_norpt (
        .i_CLK(clk), .i_RST(rst_n), .i_btn_inc_n(1'b1), .i_btn_dec_n(dec2_n),
        .o_inc_btn(inc2_btn), .o_dec_btn(dec2_btn), .o_inc_pulse(inc2_pulse),
        .o_dec_pulse(dec2_pulse), .o_held(held2), .o_conflict(conflict2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic inc, input logic dec, input logic dec2, input int cycles);
        inc_n  = inc;
        dec_n  = dec;
        dec2_n = dec2;
        repeat (cycles) @(negedge clk);
    endtask

    // Strobe monitor pops the scoreboard; low-run lengths of the button outputs are checked on release.
    always @(negedge clk) begin
        if (!rst_n) begin
            inc_run   = 0;
            dec_run   = 0;
            dec2_run  = 0;
            dec2_prev = 1'b1;
        end else begin
            if (inc_pulse) begin
                if (inc_q.size() == 0) checkOutput("inc_event_unexpected", cyc, -1);
                else                   checkOutput("inc_event_cycle", cyc, inc_q.pop_front());
                checkOutput("inc_btn_with_strobe", int'(inc_btn), 0);
                checkOutput("dec_btn_idle_on_inc", int'(dec_btn), 1);
            end
            if (dec_pulse) begin
                if (dec_q.size() == 0) checkOutput("dec_event_unexpected", cyc, -1);
                else                   checkOutput("dec_event_cycle", cyc, dec_q.pop_front());
            end
            if (inc2_pulse) checkOutput("inc2_event_unexpected", cyc, -1);
            if (dec2_pulse) begin
                if (dec2_q.size() == 0) checkOutput("dec2_event_unexpected", cyc, -1);
                else                    checkOutput("dec2_event_cycle", cyc, dec2_q.pop_front());
                checkOutput("dec2_btn_with_strobe", int'(dec2_btn), 0);
            end
            if (!inc_btn) inc_run++;
            else if (inc_run != 0) begin
                checkOutput("inc_btn_width", inc_run, PW);
                inc_run = 0;
            end
            if (!dec_btn) dec_run++;
            else if (dec_run != 0) begin
                checkOutput("dec_btn_width", dec_run, PW);
                dec_run = 0;
            end
            if (!dec2_btn) dec2_run++;
            else if (dec2_run != 0) begin
                checkOutput("dec2_btn_width", dec2_run, PW);
                dec2_run = 0;
            end
            if (dec2_prev && !dec2_btn) value_model -= STEP;
            dec2_prev = dec2_btn;
        end
    end

    initial begin
        int k;
        int e;
        repeat (3) @(negedge clk);
        checkOutput("rst_inc_btn", int'(inc_btn), 1);
        checkOutput("rst_dec_btn", int'(dec_btn), 1);
        checkOutput("rst_inc_pulse", int'(inc_pulse), 0);
        checkOutput("rst_dec_pulse", int'(dec_pulse), 0);
        checkOutput("rst_held", int'(held), 0);
        checkOutput("rst_conflict", int'(conflict), 0);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 3);

        $display("[TB] clean press");
        k = cyc + 1;
        inc_q.push_back(k + DEB + 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 10);
        checkOutput("held_while_pressed", int'(held), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 20);
        checkOutput("held_after_release", int'(held), 0);

        $display("[TB] bouncing press");
        applyStimulus(1'b0, 1'b1, 1'b1, 3);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, 1'b1, 1);
        k = cyc + 1;
        inc_q.push_back(k + DEB + 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 6);
        applyStimulus(1'b1, 1'b1, 1'b1, 20);

        $display("[TB] auto-repeat");
        k = cyc + 1;
        e = k + DEB + 3;
        inc_q.push_back(e);
        e = e + RDLY + 1;
        while (e <= k + 60 + DEB + 1) begin
            inc_q.push_back(e);
            e = e + RRATE + 1;
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 60);
        applyStimulus(1'b1, 1'b1, 1'b1, 25);

        $display("[TB] conflict lock");
        k = cyc + 1;
        inc_q.push_back(k + DEB + 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 15);
        applyStimulus(1'b0, 1'b0, 1'b1, 15);
        checkOutput("conflict_both_held", int'(conflict), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 15);
        checkOutput("conflict_one_released", int'(conflict), 1);
        checkOutput("held_in_lock", int'(held), 1);
        applyStimulus(1'b1, 1'b1, 1'b1, 15);
        checkOutput("conflict_cleared", int'(conflict), 0);

        $display("[TB] reset mid-pulse");
        k = cyc + 1;
        inc_q.push_back(k + DEB + 3);
        applyStimulus(1'b0, 1'b1, 1'b1, DEB + 4);
        #1;
        checkOutput("inc_btn_low_before_reset", int'(inc_btn), 0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_inc_btn", int'(inc_btn), 1);
        checkOutput("midrst_dec_btn", int'(dec_btn), 1);
        checkOutput("midrst_inc_pulse", int'(inc_pulse), 0);
        checkOutput("midrst_dec_pulse", int'(dec_pulse), 0);
        checkOutput("midrst_held", int'(held), 0);
        checkOutput("midrst_conflict", int'(conflict), 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        k = cyc + 1;
        inc_q.push_back(k + DEB + 3);
        applyStimulus(1'b0, 1'b1, 1'b1, 15);
        applyStimulus(1'b1, 1'b1, 1'b1, 20);

        $display("[TB] repeat disabled");
        k = cyc + 1;
        dec2_q.push_back(k + DEB + 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 100);
        applyStimulus(1'b1, 1'b1, 1'b1, 20);
        checkOutput("value_after_dec", value_model, 100 - STEP);

        checkOutput("inc_events_missing", inc_q.size(), 0);
        checkOutput("dec_events_missing", dec_q.size(), 0);
        checkOutput("dec2_events_missing", dec2_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw active-low push-buttons (KEY inputs) into clean, debounced step events for the value-control blocks (`value_control`, `theta_control`, `phi_control`). It synchronises and debounces each button. It emits one step event per press, plus auto-repeat events while the button is held. Each event is presented as an active-low button pulse, directly consumable by the falling-edge detector of `value_control`, and as a one-cycle active-high strobe.

## Interface

- DEBOUNCE_CYCLES, default 500000: consecutive stable synchronised samples required to accept a level change (10 ms at 50 MHz).
- REPEAT_EN, default 1: 1 enables auto-repeat; 0 gives one event per press.
- REPEAT_DELAY_CYCLES, default 25000000: hold time from the first event to the first repeat event.
- REPEAT_RATE_CYCLES, default 5000000: interval between subsequent repeat events. Must be ≥ 2*PULSE_CYCLES.
- PULSE_CYCLES, default 4: low width of o_inc_btn / o_dec_btn per event. Must be ≥ 1.
- CNT_BIT, default 26: width of the internal debounce and repeat counters. Must hold the largest cycle parameter.
- i_CLK  in  1  system clock.
- i_RST  in  1  asynchronous, active-low reset.
- i_btn_inc_n  in  1  raw increase button, active-low, asynchronous to i_CLK.
- i_btn_dec_n  in  1  raw decrease button, active-low, asynchronous to i_CLK.
- o_inc_btn  out  1  conditioned increase button, idle high, low for PULSE_CYCLES per event.
- o_dec_btn  out  1  conditioned decrease button, idle high, low for PULSE_CYCLES per event.
- o_inc_pulse  out  1  one-cycle strobe per increase event.
- o_dec_pulse  out  1  one-cycle strobe per decrease event.
- o_held  out  1  high while either debounced button is pressed.
- o_conflict  out  1  high while in the LOCK state.

## Operation

- Synchroniser: two flops per input. Reset value is 1 (released).
- Debounce, per channel:
  - A counter runs while the synchronised sample differs from the debounced state, and clears to 0 on any matching sample.
  - When the count reaches DEBOUNCE_CYCLES, the debounced state toggles and the counter clears.
  - The counter saturates and never wraps.
- Shared FSM over both debounced buttons: IDLE, FIRST, HOLD, REPEAT, LOCK.
  - IDLE: exactly one button pressed → FIRST. Both pressed in the same cycle → LOCK with no event.
  - FIRST: emit one event for the pressed channel. The repeat counter loads REPEAT_DELAY_CYCLES. Go to HOLD.
  - HOLD: counter decrements.
    - Release → IDLE.
    - Other button pressed → LOCK.
    - Counter reaches 0 with REPEAT_EN=1 → emit event, load REPEAT_RATE_CYCLES, go to REPEAT.
    - REPEAT_EN=0 → remain in HOLD until release.
  - REPEAT: on each counter expiry, emit an event and reload REPEAT_RATE_CYCLES. Release → IDLE. Other button pressed → LOCK.
  - LOCK: no new events. Exit to IDLE only when both buttons are released.
- Event emission:
  - The strobe is high for exactly one cycle.
  - The matching o_*_btn goes low in the same cycle and stays low PULSE_CYCLES cycles. A per-channel pulse counter times this.
  - A pulse already in progress always completes its full width, even after release, LOCK, or a transition to IDLE.
  - The two channels never pulse simultaneously.
- Reset (asynchronous, at any time, including mid-pulse):
  - FSM → IDLE; all counters 0; debounced states released.
  - o_inc_btn = o_dec_btn = 1; o_inc_pulse = o_dec_pulse = 0; o_held = 0; o_conflict = 0.

## Timing

- Press latency: raw edge first sampled low at clock edge k → strobe and o_*_btn low from edge k+DEBOUNCE_CYCLES+3.
  - 2 cycles synchroniser, DEBOUNCE_CYCLES cycles debounce, 1 cycle FSM.
- First repeat: REPEAT_DELAY_CYCLES+1 cycles after the first event strobe. Subsequent repeats: every REPEAT_RATE_CYCLES+1 cycles.
- Release latency: DEBOUNCE_CYCLES+2 cycles to the debounced release. No event is emitted after that cycle.
- Glitch rejection: any bounce shorter than DEBOUNCE_CYCLES samples produces no event and restarts the count.
- All outputs are registered. There is no combinational path from input to output.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8, PULSE_CYCLES=2, REPEAT_EN=1.

1. Clean inc press held 10 cycles, then released → one o_inc_pulse at cycle 7 after the first low sample. o_inc_btn low for exactly 2 cycles. No repeat, no dec activity.
2. Inc input bouncing (low 3, high 1, low 2, high 1) then stable low for 6 cycles → exactly one event, timed from the start of the stable-low run.
3. Inc held 60 cycles → events at t0, t0+21, t0+30, t0+39, …. Each o_inc_btn low pulse is 2 cycles, separated by high gaps. Events stop within DEBOUNCE_CYCLES+2 cycles of release.
4. Inc held, then dec pressed at cycle 15 → o_conflict=1. No further events until both are released. Releasing only dec keeps LOCK. Releasing both returns to IDLE and o_conflict=0.
5. Assert i_RST low during an o_inc_btn low pulse → outputs immediately 1/0/0/0. After release of reset with the button still held, a fresh event arrives DEBOUNCE_CYCLES+3 cycles later.
6. REPEAT_EN=0, dec held 100 cycles → exactly one o_dec_pulse. Drive value_control from o_dec_btn and check its count decrements by exactly INTEGER_STEP.
